// File: rtl/shift_add_acc.sv
// shift_add_acc: frame accumulator placed after the combinational shift-add
// multiplier. It sums one 2*N-bit product per accepted beat until in_last
// arrives or MAX_TERMS products have been taken. The frame total is then held
// behind a valid/ready handshake.
//
// Handshake rules:
//   - An input beat transfers on a rising edge when in_valid && in_ready.
//   - A result transfers on a rising edge when out_valid && out_ready.
//   - in_ready and out_valid depend on the state register only. in_ready is
//     never high while out_valid is high, so one edge can never both complete
//     a result and start a new frame.
//
// Optional build macro SHIFT_ADD_ACC_SAT_EN:
//   - Defined:   a carry out of ACC_W bits clamps the sum to all-ones.
//   - Undefined: the sum wraps modulo 2^ACC_W.
//   In both builds the sticky overflow flag is set.
//
// Debug visibility: state_q (type state_e) is the single FSM state register
// and can be probed hierarchically.

module shift_add_acc #(
  parameter  int N         = 4,
  parameter  int ACC_W     = 12,
  parameter  int MAX_TERMS = 16,
  localparam int CW        = $clog2(MAX_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   product,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CW-1:0]    out_count,
  output logic             overflow
);

  // One extra bit on the adder catches the carry out of ACC_W.
  localparam int            SW      = ACC_W + 1;
  localparam logic [CW-1:0] ONE_CNT = CW'(1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_TERMS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q,   acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q,   ovf_d;

  logic             beat;
  logic [SW-1:0]    sum;
  logic             carry;
  logic [ACC_W-1:0] acc_next;

  // Running sum plus the incoming product. The product is zero-extended.
  always_comb begin
    sum      = {1'b0, acc_q} + SW'(product);
    carry    = sum[ACC_W];
`ifdef SHIFT_ADD_ACC_SAT_EN
    // Once clamped, the value stays at all-ones: any further nonzero add
    // carries again, and adding zero leaves it unchanged.
    acc_next = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    acc_next = sum[ACC_W-1:0];
`endif
  end

  // Next-state and datapath update. The handshake outputs are decoded from
  // the state register alone.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    in_ready  = (state_q != HOLD);
    out_valid = (state_q == HOLD);
    beat      = in_valid && in_ready;

    case (state_q)
      IDLE: begin
        if (beat) begin
          // The first term of a frame replaces the previous frame's result.
          acc_d   = ACC_W'(product);
          count_d = ONE_CNT;
          ovf_d   = 1'b0;
          state_d = (in_last || (MAX_TERMS == 1)) ? HOLD : ACCUM;
        end
      end

      ACCUM: begin
        if (beat) begin
          acc_d   = acc_next;
          count_d = count_q + ONE_CNT;
          ovf_d   = ovf_q | carry;
          // Reaching MAX_TERMS ends the frame as if in_last had been set.
          state_d = (in_last || (count_d == MAX_CNT)) ? HOLD : ACCUM;
        end
      end

      HOLD: begin
        // The result stays frozen until the consumer takes it.
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers. Reset has priority over every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign acc_out   = acc_q;
  assign out_count = count_q;
  assign overflow  = ovf_q;

  // A result waiting for the consumer must not change.
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (state_q == HOLD && !out_ready) |=>
      (state_q == HOLD && $stable(acc_q) && $stable(count_q) && $stable(ovf_q)));

  // The term counter never runs past the frame limit.
  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    count_q <= MAX_CNT);

  // The stage never asks for input while it is presenting a result.
  a_ready_excl: assert property (@(posedge clk) disable iff (rst)
    !(in_ready && out_valid));

endmodule

// File: doc/shift_add_acc.md
Name: shift_add_acc

Overview:
- Accumulator stage directly downstream of the combinational shift-add multiplier.
- Consumes one 2N-bit product per accepted beat and sums a frame of products (dot-product style).
- Presents the frame total with a valid/ready handshake.
- Registered, one clock domain; adds the sequencing the multiplier lacks.

Parameters:
- N, 4, operand width of upstream multiplier; product input is 2*N bits
- ACC_W, 12, accumulator/result width; must be >= 2*N
- MAX_TERMS, 16, maximum products per frame; 1..255

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  product beat valid
- in_ready  output  1  stage can accept a beat
- product  input  2*N  multiplier result, zero-extended to ACC_W internally
- in_last  input  1  beat is final term of frame
- out_valid  output  1  acc_out/out_count/overflow hold a completed frame
- out_ready  input  1  downstream accepts result
- acc_out  output  ACC_W  frame sum
- out_count  output  $clog2(MAX_TERMS+1)  number of terms summed
- overflow  output  1  sum exceeded 2^ACC_W-1 during frame (sticky per frame)

Behaviour:
- Reset (rst=1 at edge): state IDLE, acc_out=0, out_count=0, overflow=0, out_valid=0. in_ready=1 from the next cycle.
- Reset wins over every other event. Mid-frame reset discards the partial sum; no result is emitted.
- Beat accepted when in_valid && in_ready at a rising edge.
- FSM states: IDLE, ACCUM, HOLD.
- in_ready = 1 in IDLE and ACCUM, 0 in HOLD (combinational from state only).
- out_valid = 1 only in HOLD.
- IDLE + accepted beat:
  - acc = product, count = 1, overflow = 0.
  - Next state HOLD if in_last or MAX_TERMS==1, else ACCUM.
- ACCUM + accepted beat:
  - acc = acc + product, count = count + 1.
  - Overflow: carry out of ACC_W bits sets overflow, and acc wraps modulo 2^ACC_W.
  - Next state HOLD if in_last or the new count == MAX_TERMS; that beat acts as implicit last. Otherwise stay in ACCUM.
- ACCUM with no beat: hold all values.
- HOLD: acc_out, out_count and overflow are stable.
  - out_ready=1 at an edge completes the transfer; next state IDLE.
  - Registers keep their last value; out_valid drops.
  - A new frame may be accepted the cycle after the transfer, not in the same cycle. in_ready is 0 during HOLD.
- Latency: out_valid rises on the edge that accepts the final beat, so it is visible the same cycle that edge completes. Minimum frame-to-frame spacing is final beat + 1 HOLD cycle.
- in_last outside an accepted beat is ignored.
- product is sampled only on an accepted beat.
- Arithmetic is unsigned. product is zero-extended to ACC_W+1 bits for the add; bit ACC_W is the carry.

Optional Feature:
- Macro SHIFT_ADD_ACC_SAT_EN.
- Defined: on carry, acc saturates to all-ones (2^ACC_W-1) and stays there for the rest of the frame. overflow is still set.
- Undefined: wrap modulo 2^ACC_W, overflow set.
- Handshake, FSM and count behaviour are identical in both builds.

Test Plan:
- Single beat: product=42, in_last=1 -> next cycle out_valid=1, acc_out=42, out_count=1, overflow=0. out_ready=1 -> IDLE, in_ready=1.
- Three beats of 225 (15*15), last on third -> acc_out=675, out_count=3, overflow=0.
- Backpressure: complete frame {3,4}, hold out_ready=0 for 5 cycles while driving in_valid=1 with product=99.
  - Required: in_ready=0, acc_out=7 stable, 99 not absorbed.
  - Raise out_ready -> IDLE; next accepted beat 99 starts a new frame.
- Overflow with MAX_TERMS=32: 19 beats of 225, last on 19th (true sum 4275).
  - Without macro: acc_out=179, overflow=1.
  - With SHIFT_ADD_ACC_SAT_EN: acc_out=4095, overflow=1.
- Forced end with MAX_TERMS=16: 20 continuous beats of product=1, in_last=0.
  - Required: HOLD after 16th beat, acc_out=16, out_count=16.
  - Beats 17-20 are stalled (in_ready=0) and begin the next frame after the handshake.
- Reset mid-frame: accept 5 and 6, assert rst one cycle.
  - Required: out_valid=0, acc_out=0, out_count=0.
  - Then a frame {2, last} yields acc_out=2, out_count=1.
